// File: rtl/pci_target_ctrl.sv
// PCI target for a 16-word register window: decodes the address phase, answers with
// DEVSEL#/TRDY#/STOP#, moves burst data to/from the window and checks/generates parity.
module pci_target_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_n,
    input  logic        irdy_n,
    inout  wire  [31:0] ad,
    inout  wire  [3:0]  c_be,
    inout  wire         par,
    output logic        trdy_n,
    output logic        devsel_n,
    output logic        stop_n,
    output logic        perr_n
);
    localparam logic [3:0] CMD_MEM_RD = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE, S_BUSY, S_RTURN, S_RDATA, S_WDATA, S_DISC
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] mem_q [16];

    logic        trdy_n_q, devsel_n_q, stop_n_q, perr_n_q;
    logic        ad_oe_q, par_oe_q, par_out_q;
    logic [31:0] ad_out_q;
    logic        chk_pend_q, exp_par_q, perr_pend_q;

    logic        hit, xfer, wr_xfer, data_d;

    assign hit     = (ad[31:6] == BASE_ADDR[31:6]);
    assign xfer    = ((state_q == S_WDATA) || (state_q == S_RDATA)) && !irdy_n;
    assign wr_xfer = xfer && (state_q == S_WDATA);
    assign data_d  = (state_d == S_WDATA) || (state_d == S_RDATA);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (!frame_n) begin
                    idx_d = ad[5:2];
                    if (hit && (c_be == CMD_MEM_WR))      state_d = S_WDATA;
                    else if (hit && (c_be == CMD_MEM_RD)) state_d = S_RTURN;
                    else                                  state_d = S_BUSY;
                end
            end
            S_BUSY:  if (frame_n && irdy_n) state_d = S_IDLE;
            S_RTURN: state_d = S_RDATA;
            S_WDATA, S_RDATA: begin
                if (xfer) begin
                    // The window does not wrap; a transfer at the top word ends the burst.
                    if (idx_q != 4'd15) idx_d = idx_q + 4'd1;
                    if (frame_n)              state_d = S_IDLE;
                    else if (idx_q == 4'd15)  state_d = S_DISC;
                end
            end
            S_DISC:  if (frame_n) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            idx_q       <= 4'd0;
            trdy_n_q    <= 1'b1;
            devsel_n_q  <= 1'b1;
            stop_n_q    <= 1'b1;
            perr_n_q    <= 1'b1;
            ad_oe_q     <= 1'b0;
            ad_out_q    <= 32'd0;
            par_oe_q    <= 1'b0;
            par_out_q   <= 1'b0;
            chk_pend_q  <= 1'b0;
            exp_par_q   <= 1'b0;
            perr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            devsel_n_q <= !(data_d || (state_d == S_RTURN) || (state_d == S_DISC));
            trdy_n_q   <= !data_d;
            stop_n_q   <= !((data_d && (idx_d == 4'd15)) || (state_d == S_DISC));
            ad_oe_q    <= (state_d == S_RDATA);
            ad_out_q   <= mem_q[idx_d];
            // Read parity trails the driven data by one clock.
            par_oe_q   <= ad_oe_q;
            par_out_q  <= (^ad_out_q) ^ (^c_be);
            // Write parity: expect at transfer, compare next edge, flag one edge later.
            chk_pend_q  <= wr_xfer;
            exp_par_q   <= (^ad) ^ (^c_be);
            perr_pend_q <= chk_pend_q && (par != exp_par_q);
            perr_n_q    <= !perr_pend_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int w = 0; w < 16; w++) mem_q[w] <= 32'd0;
        end else if (wr_xfer) begin
            for (int b = 0; b < 4; b++) begin
                if (!c_be[b]) mem_q[idx_q][8*b +: 8] <= ad[8*b +: 8];
            end
        end
    end

    assign ad       = ad_oe_q  ? ad_out_q  : 32'bz;
    assign par      = par_oe_q ? par_out_q : 1'bz;
    assign trdy_n   = trdy_n_q;
    assign devsel_n = devsel_n_q;
    assign stop_n   = stop_n_q;
    assign perr_n   = perr_n_q;

endmodule

// File: tb/tb_pci_target_ctrl.sv
// Directed bench for pci_target_ctrl: the bench acts as bus master, keeps a model of the
// register window and a scoreboard of expected read words. Floating ad/par read back as 1.
module tb_pci_target_ctrl;
    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        frame_n   = 1'b1;
    logic        irdy_n    = 1'b1;
    logic [31:0] tb_ad     = 32'd0;
    logic        tb_ad_oe  = 1'b0;
    logic [3:0]  tb_cbe    = 4'b0000;
    logic        tb_par    = 1'b0;
    logic        tb_par_oe = 1'b0;

    tri1 [31:0]  ad;
    wire [3:0]   c_be;
    tri1         par;
    wire         trdy_n, devsel_n, stop_n, perr_n;

    assign ad   = tb_ad_oe  ? tb_ad  : 32'bz;
    assign c_be = tb_cbe;
    assign par  = tb_par_oe ? tb_par : 1'bz;

    pci_target_ctrl #(.BASE_ADDR(32'h0000_1000)) dut (
        .clk      (clk),
        .rst      (rst),
        .frame_n  (frame_n),
        .irdy_n   (irdy_n),
        .ad       (ad),
        .c_be     (c_be),
        .par      (par),
        .trdy_n   (trdy_n),
        .devsel_n (devsel_n),
        .stop_n   (stop_n),
        .perr_n   (perr_n)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          perr_low_cyc = -1;
    logic [31:0] model [16];
    logic [31:0] sb [$];
    logic [31:0] wd [4];
    logic [3:0]  wbe [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; perr_n is expected low only in the cycle two edges after a bad write.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        chk("perr", {31'd0, perr_n}, (cyc == perr_low_cyc) ? 32'd0 : 32'd1);
    endtask

    task automatic write_burst(input logic [31:0] addr, input int n, input int wait_at,
                               input int bad_at);
        int   idx;
        logic p;
        idx = int'(addr[5:2]);
        $display("[TB] write addr=%h words=%0d wait_at=%0d bad_par_at=%0d", addr, n, wait_at, bad_at);
        frame_n = 1'b0; irdy_n = 1'b1; tb_ad = addr; tb_ad_oe = 1'b1; tb_cbe = 4'b0111;
        tick();
        chk("wr_e0_devsel", {31'd0, devsel_n}, 32'd0);
        chk("wr_e0_trdy", {31'd0, trdy_n}, 32'd0);
        for (int k = 0; k < n; k++) begin
            if (k == wait_at) begin
                for (int w = 0; w < 2; w++) begin
                    irdy_n = 1'b1; tb_ad = wd[k]; tb_cbe = wbe[k];
                    tick();
                    tb_par_oe = 1'b0;
                    chk("wr_wait_trdy", {31'd0, trdy_n}, 32'd0);
                end
            end
            irdy_n = 1'b0; tb_ad = wd[k]; tb_cbe = wbe[k]; frame_n = (k == n - 1);
            chk("wr_stop", {31'd0, stop_n}, (idx == 15) ? 32'd0 : 32'd1);
            tick();
            for (int b = 0; b < 4; b++) begin
                if (!wbe[k][b]) model[idx][8*b +: 8] = wd[k][8*b +: 8];
            end
            p = (^wd[k]) ^ (^wbe[k]);
            if (k == bad_at) begin
                p = ~p;
                perr_low_cyc = cyc + 2;
            end
            tb_par = p; tb_par_oe = 1'b1;
            idx++;
        end
        chk("wr_done_trdy", {31'd0, trdy_n}, 32'd1);
        chk("wr_done_devsel", {31'd0, devsel_n}, 32'd1);
        chk("wr_done_stop", {31'd0, stop_n}, 32'd1);
        frame_n = 1'b1; irdy_n = 1'b1; tb_ad_oe = 1'b0; tb_cbe = 4'b0000;
        tick();
        tb_par_oe = 1'b0;
    endtask

    task automatic read_burst(input logic [31:0] addr, input int n, input int wait_at,
                              input bit hold);
        int          idx;
        logic [31:0] exp;
        idx = int'(addr[5:2]);
        $display("[TB] read  addr=%h words=%0d wait_at=%0d hold_frame=%0d", addr, n, wait_at, hold);
        for (int k = 0; k < n; k++) sb.push_back(model[idx + k]);
        frame_n = 1'b0; irdy_n = 1'b1; tb_ad = addr; tb_ad_oe = 1'b1; tb_cbe = 4'b0110;
        tick();
        tb_ad_oe = 1'b0; tb_cbe = 4'b0000;
        #1;
        chk("rd_turn_devsel", {31'd0, devsel_n}, 32'd0);
        chk("rd_turn_trdy", {31'd0, trdy_n}, 32'd1);
        chk("rd_turn_ad", ad, 32'hFFFF_FFFF);
        tick();
        chk("rd_first_par_idle", {31'd0, par}, 32'd1);
        for (int k = 0; k < n; k++) begin
            exp = sb.pop_front();
            if (k == wait_at) begin
                for (int w = 0; w < 2; w++) begin
                    irdy_n = 1'b1;
                    chk("rd_wait_ad", ad, exp);
                    chk("rd_wait_trdy", {31'd0, trdy_n}, 32'd0);
                    tick();
                    chk("rd_wait_par", {31'd0, par}, {31'd0, ^exp});
                end
            end
            irdy_n = 1'b0; frame_n = (k == n - 1) && !hold;
            chk("rd_data", ad, exp);
            chk("rd_trdy", {31'd0, trdy_n}, 32'd0);
            chk("rd_devsel", {31'd0, devsel_n}, 32'd0);
            chk("rd_stop", {31'd0, stop_n}, (idx == 15) ? 32'd0 : 32'd1);
            tick();
            chk("rd_par", {31'd0, par}, {31'd0, ^exp});
            idx++;
        end
        if (hold) begin
            chk("disc_trdy", {31'd0, trdy_n}, 32'd1);
            chk("disc_stop", {31'd0, stop_n}, 32'd0);
            chk("disc_devsel", {31'd0, devsel_n}, 32'd0);
            chk("disc_ad", ad, 32'hFFFF_FFFF);
            irdy_n = 1'b1;
            tick();
            chk("disc_hold_stop", {31'd0, stop_n}, 32'd0);
            chk("disc_hold_trdy", {31'd0, trdy_n}, 32'd1);
            chk("disc_hold_devsel", {31'd0, devsel_n}, 32'd0);
            chk("disc_par_float", {31'd0, par}, 32'd1);
            frame_n = 1'b1;
            tick();
            chk("disc_end_stop", {31'd0, stop_n}, 32'd1);
            chk("disc_end_devsel", {31'd0, devsel_n}, 32'd1);
            chk("disc_end_trdy", {31'd0, trdy_n}, 32'd1);
        end else begin
            chk("rd_done_trdy", {31'd0, trdy_n}, 32'd1);
            chk("rd_done_devsel", {31'd0, devsel_n}, 32'd1);
            chk("rd_done_stop", {31'd0, stop_n}, 32'd1);
            chk("rd_done_ad", ad, 32'hFFFF_FFFF);
            irdy_n = 1'b1; frame_n = 1'b1;
            tick();
            chk("rd_done_par_float", {31'd0, par}, 32'd1);
        end
    endtask

    task automatic miss(input logic [31:0] addr, input logic [3:0] cmd);
        $display("[TB] miss  addr=%h cmd=%b", addr, cmd);
        frame_n = 1'b0; irdy_n = 1'b1; tb_ad = addr; tb_ad_oe = 1'b1; tb_cbe = cmd;
        tick();
        tb_ad_oe = 1'b0; tb_cbe = 4'b0000; frame_n = 1'b1; irdy_n = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("miss_devsel", {31'd0, devsel_n}, 32'd1);
            chk("miss_trdy", {31'd0, trdy_n}, 32'd1);
            chk("miss_stop", {31'd0, stop_n}, 32'd1);
            chk("miss_ad", ad, 32'hFFFF_FFFF);
            if (c == 1) irdy_n = 1'b1;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        for (int i = 0; i < 16; i++) model[i] = 32'd0;
        #2 rst = 1'b0;
        #1;
        $display("[TB] reset asserted");
        chk("rst_trdy", {31'd0, trdy_n}, 32'd1);
        chk("rst_devsel", {31'd0, devsel_n}, 32'd1);
        chk("rst_stop", {31'd0, stop_n}, 32'd1);
        chk("rst_perr", {31'd0, perr_n}, 32'd1);
        chk("rst_ad", ad, 32'hFFFF_FFFF);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Single write then read
        wd[0] = 32'hDEAD_BEEF; wbe[0] = 4'b0000;
        write_burst(32'h0000_1008, 1, -1, -1);
        read_burst(32'h0000_1008, 1, -1, 1'b0);

        // Burst write with irdy wait states, burst read back with waits
        wd[0] = 32'h0102_0304; wd[1] = 32'hA5A5_0F0F; wd[2] = 32'h1357_9BDF; wd[3] = 32'h2468_ACE0;
        for (int i = 0; i < 4; i++) wbe[i] = 4'b0000;
        write_burst(32'h0000_1000, 4, 2, -1);
        read_burst(32'h0000_1000, 4, 1, 1'b0);

        // Byte enables
        wd[0] = 32'h1122_3344; wbe[0] = 4'b0000;
        write_burst(32'h0000_1008, 1, -1, -1);
        wd[0] = 32'hAABB_CCDD; wbe[0] = 4'b1010;
        write_burst(32'h0000_1008, 1, -1, -1);
        read_burst(32'h0000_1008, 1, -1, 1'b0);

        // Misses, then a hit is accepted
        miss(32'h0000_2000, 4'b0110);
        miss(32'h0000_1000, 4'b0010);
        read_burst(32'h0000_1004, 1, -1, 1'b0);

        // Disconnect at the top of the window
        wd[0] = 32'h7654_3210; wd[1] = 32'hCAFE_F00D; wbe[0] = 4'b0000; wbe[1] = 4'b0000;
        write_burst(32'h0000_1038, 2, -1, -1);
        read_burst(32'h0000_1038, 2, -1, 1'b1);

        // Write parity error
        wd[0] = 32'h5555_AAAA; wbe[0] = 4'b0000;
        write_burst(32'h0000_1010, 1, -1, 0);
        tick();
        tick();
        tick();

        // Reset in the middle of a read burst
        wd[0] = 32'hDEAD_BEEF; wd[1] = 32'h0BAD_F00D; wbe[0] = 4'b0000; wbe[1] = 4'b0000;
        write_burst(32'h0000_1014, 2, -1, -1);
        $display("[TB] read  addr=%h interrupted by reset", 32'h0000_1014);
        frame_n = 1'b0; irdy_n = 1'b1; tb_ad = 32'h0000_1014; tb_ad_oe = 1'b1; tb_cbe = 4'b0110;
        tick();
        tb_ad_oe = 1'b0; tb_cbe = 4'b0000; irdy_n = 1'b0;
        tick();
        chk("rstb_ad0", ad, model[5]);
        tick();
        chk("rstb_par0", {31'd0, par}, {31'd0, ^model[5]});
        chk("rstb_ad1", ad, model[6]);
        rst = 1'b0;
        #1;
        chk("rstb_ad_float", ad, 32'hFFFF_FFFF);
        chk("rstb_par_float", {31'd0, par}, 32'd1);
        chk("rstb_trdy", {31'd0, trdy_n}, 32'd1);
        chk("rstb_devsel", {31'd0, devsel_n}, 32'd1);
        chk("rstb_stop", {31'd0, stop_n}, 32'd1);
        frame_n = 1'b1; irdy_n = 1'b1;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 16; i++) model[i] = 32'd0;
        sb.delete();
        tick();
        read_burst(32'h0000_1014, 2, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
